// File: rtl/branch_predictor.sv
// Branch predictor: a direct-mapped table of 2-bit saturating counters.
// Prediction is combinational at fetch, and the table is trained at the M stage.
// Optional feature: define BPRED_STATS_EN to add resolve and mispredict counters.
module branch_predictor #(
  parameter int IDX_W = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [63:0] f_pc_i,
  input  logic [3:0]  f_icode_i,
  input  logic [3:0]  f_ifun_i,
  input  logic [63:0] f_valC_i,
  input  logic [63:0] f_valP_i,
  output logic [63:0] f_pred_pc_o,
  output logic        f_pred_taken_o,
  input  logic [3:0]  M_icode_i,
  input  logic [3:0]  M_ifun_i,
  input  logic        M_valid_i,
  input  logic [63:0] M_pc_i,
  input  logic        M_Cnd_i,
  input  logic        M_pred_taken_i,
  input  logic [63:0] M_target_i,
  input  logic [63:0] M_valA_i,
  output logic        m_mispred_o,
  output logic [63:0] m_redirect_pc_o
`ifdef BPRED_STATS_EN
  ,
  output logic [31:0] stat_branches_o,
  output logic [31:0] stat_mispred_o
`endif
);

  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam int         ENTRIES = 1 << IDX_W;

  logic [1:0]       bht [ENTRIES];
  logic [IDX_W-1:0] f_idx;
  logic [IDX_W-1:0] m_idx;
  logic [1:0]       f_ctr;
  logic [1:0]       m_ctr;
  logic             resolve;

  // The table has no tags, so only the low PC bits select an entry.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{f_pc_i[63:IDX_W], M_pc_i[63:IDX_W]};

  assign f_idx   = f_pc_i[IDX_W-1:0];
  assign m_idx   = M_pc_i[IDX_W-1:0];
  assign f_ctr   = bht[f_idx];
  assign m_ctr   = bht[m_idx];
  assign resolve = M_valid_i && (M_icode_i == IJXX) && (M_ifun_i != 4'h0);

  // Fetch prediction reads the stored counter, so a same-cycle update is not yet visible.
  always_comb begin
    f_pred_taken_o = 1'b0;
    f_pred_pc_o    = f_valP_i;
    if (f_icode_i == IJXX) begin
      if (f_ifun_i == 4'h0 || f_ctr[1]) begin
        f_pred_taken_o = 1'b1;
        f_pred_pc_o    = f_valC_i;
      end
    end else if (f_icode_i == ICALL) begin
      f_pred_pc_o = f_valC_i;
    end
  end

  // A misprediction is only possible for a real conditional jump; redirect is zero otherwise.
  always_comb begin
    m_mispred_o     = resolve && (M_Cnd_i != M_pred_taken_i);
    m_redirect_pc_o = 64'h0;
    if (m_mispred_o) begin
      m_redirect_pc_o = M_Cnd_i ? M_target_i : M_valA_i;
    end
  end

  // Train the resolved entry toward the actual outcome, saturating at both ends.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        bht[i] <= 2'b10;
      end
    end else if (resolve) begin
      if (M_Cnd_i && m_ctr != 2'b11) begin
        bht[m_idx] <= m_ctr + 2'b01;
      end else if (!M_Cnd_i && m_ctr != 2'b00) begin
        bht[m_idx] <= m_ctr - 2'b01;
      end
    end
  end

`ifdef BPRED_STATS_EN
  logic [31:0] stat_branches_q;
  logic [31:0] stat_mispred_q;

  // Count resolve events and mispredict cycles, sticking at the all-ones value.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stat_branches_q <= 32'h0;
      stat_mispred_q  <= 32'h0;
    end else begin
      if (resolve && stat_branches_q != 32'hFFFF_FFFF) begin
        stat_branches_q <= stat_branches_q + 32'h1;
      end
      if (m_mispred_o && stat_mispred_q != 32'hFFFF_FFFF) begin
        stat_mispred_q <= stat_mispred_q + 32'h1;
      end
    end
  end

  assign stat_branches_o = stat_branches_q;
  assign stat_mispred_o  = stat_mispred_q;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor using a reference model and scoreboard queue.
// Define BPRED_STATS_EN when compiling to also exercise the statistics outputs.
module tb_branch_predictor;

  localparam logic [3:0] IJXX  = 4'h7;
  localparam logic [3:0] ICALL = 4'h8;

  typedef struct packed {
    logic [63:0] pred_pc;
    logic        taken;
    logic        mispred;
    logic [63:0] redirect;
  } exp_t;

  logic        clk_i;
  logic        rst_n_i;
  logic [63:0] f_pc_i;
  logic [3:0]  f_icode_i;
  logic [3:0]  f_ifun_i;
  logic [63:0] f_valC_i;
  logic [63:0] f_valP_i;
  logic [63:0] f_pred_pc_o;
  logic        f_pred_taken_o;
  logic [3:0]  M_icode_i;
  logic [3:0]  M_ifun_i;
  logic        M_valid_i;
  logic [63:0] M_pc_i;
  logic        M_Cnd_i;
  logic        M_pred_taken_i;
  logic [63:0] M_target_i;
  logic [63:0] M_valA_i;
  logic        m_mispred_o;
  logic [63:0] m_redirect_pc_o;
`ifdef BPRED_STATS_EN
  logic [31:0] stat_branches_o;
  logic [31:0] stat_mispred_o;
  logic [31:0] stat_b;
  logic [31:0] stat_m;
`endif

  int   n_compared;
  int   n_mismatched;
  int   mdl [16];
  exp_t sb [$];

  branch_predictor #(.IDX_W(4)) dut (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .f_pc_i         (f_pc_i),
    .f_icode_i      (f_icode_i),
    .f_ifun_i       (f_ifun_i),
    .f_valC_i       (f_valC_i),
    .f_valP_i       (f_valP_i),
    .f_pred_pc_o    (f_pred_pc_o),
    .f_pred_taken_o (f_pred_taken_o),
    .M_icode_i      (M_icode_i),
    .M_ifun_i       (M_ifun_i),
    .M_valid_i      (M_valid_i),
    .M_pc_i         (M_pc_i),
    .M_Cnd_i        (M_Cnd_i),
    .M_pred_taken_i (M_pred_taken_i),
    .M_target_i     (M_target_i),
    .M_valA_i       (M_valA_i),
    .m_mispred_o    (m_mispred_o),
    .m_redirect_pc_o(m_redirect_pc_o)
`ifdef BPRED_STATS_EN
    ,
    .stat_branches_o(stat_branches_o),
    .stat_mispred_o (stat_mispred_o)
`endif
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Hard bound on the run so a stuck bench still terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Expected outputs for the currently driven inputs, from the counter model.
  function automatic exp_t model_expect();
    exp_t e;
    int   c;
    logic res;
    c         = mdl[int'(f_pc_i[3:0])];
    e.taken   = 1'b0;
    e.pred_pc = f_valP_i;
    if (f_icode_i == IJXX) begin
      if (f_ifun_i == 4'h0 || c >= 2) begin
        e.taken   = 1'b1;
        e.pred_pc = f_valC_i;
      end
    end else if (f_icode_i == ICALL) begin
      e.pred_pc = f_valC_i;
    end
    res        = M_valid_i && (M_icode_i == IJXX) && (M_ifun_i != 4'h0);
    e.mispred  = res && (M_Cnd_i != M_pred_taken_i);
    e.redirect = e.mispred ? (M_Cnd_i ? M_target_i : M_valA_i) : 64'h0;
    return e;
  endfunction

  // Advance the model as the rising edge just did.
  task automatic model_update();
    int   idx;
    logic res;
    if (rst_n_i) begin
      res = M_valid_i && (M_icode_i == IJXX) && (M_ifun_i != 4'h0);
      idx = int'(M_pc_i[3:0]);
      if (res) begin
        if (M_Cnd_i && mdl[idx] < 3) mdl[idx]++;
        else if (!M_Cnd_i && mdl[idx] > 0) mdl[idx]--;
`ifdef BPRED_STATS_EN
        if (stat_b != 32'hFFFF_FFFF) stat_b++;
        if (M_Cnd_i != M_pred_taken_i && stat_m != 32'hFFFF_FFFF) stat_m++;
`endif
      end
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mdl[i] = 2;
`ifdef BPRED_STATS_EN
    stat_b = 32'h0;
    stat_m = 32'h0;
`endif
  endtask

  task automatic set_fetch(input logic [63:0] pc, input logic [3:0] ic, input logic [3:0] fn,
                           input logic [63:0] vc, input logic [63:0] vp);
    f_pc_i    = pc;
    f_icode_i = ic;
    f_ifun_i  = fn;
    f_valC_i  = vc;
    f_valP_i  = vp;
  endtask

  task automatic set_mem(input logic v, input logic [63:0] pc, input logic [3:0] ic,
                         input logic [3:0] fn, input logic c, input logic pt,
                         input logic [63:0] tg, input logic [63:0] va);
    M_valid_i      = v;
    M_pc_i         = pc;
    M_icode_i      = ic;
    M_ifun_i       = fn;
    M_Cnd_i        = c;
    M_pred_taken_i = pt;
    M_target_i     = tg;
    M_valA_i       = va;
  endtask

  // Reset state: every entry predicts a conditional jump taken.
  task automatic test_reset();
    exp_t e;
    rst_n_i = 1'b0;
    set_fetch(64'h0, 4'h1, 4'h0, 64'h0, 64'h0);
    set_mem(1'b1, 64'h10, IJXX, 4'h1, 1'b0, 1'b1, 64'h0, 64'h0);
    model_reset();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    set_mem(1'b0, 64'h0, 4'h0, 4'h0, 1'b0, 1'b0, 64'h0, 64'h0);
    for (int i = -1; i < 16; i++) begin
      @(negedge clk_i);
      if (i < 0) set_fetch(64'h10, IJXX, 4'h1, 64'h100, 64'h19);
      else set_fetch(64'h1000 + 64'(i), IJXX, 4'h2, 64'h100 + 64'(i), 64'h9 + 64'(i));
      sb.push_back(model_expect());
      #2;
      e = sb.pop_front();
      n_compared++;
      if (f_pred_pc_o !== e.pred_pc || f_pred_taken_o !== e.taken ||
          m_mispred_o !== e.mispred || m_redirect_pc_o !== e.redirect) begin
        n_mismatched++;
        $display("[TB] FAIL test_reset[%0d]: got pc=%h tk=%b mp=%b rd=%h, want pc=%h tk=%b mp=%b rd=%h",
                 i, f_pred_pc_o, f_pred_taken_o, m_mispred_o, m_redirect_pc_o,
                 e.pred_pc, e.taken, e.mispred, e.redirect);
      end
      @(posedge clk_i);
      model_update();
    end
  endtask

  // Three not-taken resolves drive the counter down to zero; the alias index then predicts fall-through.
  task automatic test_not_taken_train();
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      if (i < 3) begin
        set_fetch(64'h40, 4'h1, 4'h0, 64'h0, 64'h41);
        set_mem(1'b1, 64'h10, IJXX, 4'h2, 1'b0, 1'b1, 64'h300, 64'h19 + 64'(i));
      end else begin
        set_fetch(64'h20, IJXX, 4'h1, 64'h120, 64'h29);
        set_mem(1'b0, 64'h0, 4'h0, 4'h0, 1'b0, 1'b0, 64'h0, 64'h0);
      end
      sb.push_back(model_expect());
      #2;
      e = sb.pop_front();
      n_compared++;
      if (f_pred_pc_o !== e.pred_pc || f_pred_taken_o !== e.taken ||
          m_mispred_o !== e.mispred || m_redirect_pc_o !== e.redirect) begin
        n_mismatched++;
        $display("[TB] FAIL test_not_taken_train[%0d]: got pc=%h tk=%b mp=%b rd=%h, want pc=%h tk=%b mp=%b rd=%h",
                 i, f_pred_pc_o, f_pred_taken_o, m_mispred_o, m_redirect_pc_o,
                 e.pred_pc, e.taken, e.mispred, e.redirect);
      end
      @(posedge clk_i);
      model_update();
    end
  endtask

  // Same-index fetch and resolve: prediction sees the old counter, the new one a cycle later.
  task automatic test_same_cycle();
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      set_fetch(64'h30, IJXX, 4'h3, 64'h400, 64'h39);
      if (i == 0 || i == 2) set_mem(1'b1, 64'h10, IJXX, 4'h1, 1'b1, 1'b0, 64'h200, 64'h19);
      else set_mem(1'b0, 64'h0, 4'h0, 4'h0, 1'b0, 1'b0, 64'h0, 64'h0);
      sb.push_back(model_expect());
      #2;
      e = sb.pop_front();
      n_compared++;
      if (f_pred_pc_o !== e.pred_pc || f_pred_taken_o !== e.taken ||
          m_mispred_o !== e.mispred || m_redirect_pc_o !== e.redirect) begin
        n_mismatched++;
        $display("[TB] FAIL test_same_cycle[%0d]: got pc=%h tk=%b mp=%b rd=%h, want pc=%h tk=%b mp=%b rd=%h",
                 i, f_pred_pc_o, f_pred_taken_o, m_mispred_o, m_redirect_pc_o,
                 e.pred_pc, e.taken, e.mispred, e.redirect);
      end
      @(posedge clk_i);
      model_update();
    end
  endtask

  // jmp, bubbles and non-jumps leave the table alone; jmp/call/other fetch rules.
  task automatic test_no_update();
    exp_t e;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk_i);
      set_fetch(64'h0, IJXX, 4'h1, 64'h500, 64'h9);
      set_mem(1'b0, 64'h0, 4'h0, 4'h0, 1'b0, 1'b0, 64'h0, 64'h0);
      case (i)
        0: set_mem(1'b1, 64'h10, IJXX, 4'h0, 1'b0, 1'b1, 64'h600, 64'h19);
        1: set_mem(1'b0, 64'h10, IJXX, 4'h1, 1'b0, 1'b1, 64'h600, 64'h19);
        2: set_mem(1'b1, 64'h10, 4'h6, 4'h1, 1'b0, 1'b1, 64'h600, 64'h19);
        4: set_fetch(64'h0, IJXX, 4'h0, 64'h700, 64'h9);
        5: set_fetch(64'h0, ICALL, 4'h0, 64'h800, 64'h9);
        6: set_fetch(64'h0, 4'h6, 4'h0, 64'h900, 64'h2);
        default: ;
      endcase
      sb.push_back(model_expect());
      #2;
      e = sb.pop_front();
      n_compared++;
      if (f_pred_pc_o !== e.pred_pc || f_pred_taken_o !== e.taken ||
          m_mispred_o !== e.mispred || m_redirect_pc_o !== e.redirect) begin
        n_mismatched++;
        $display("[TB] FAIL test_no_update[%0d]: got pc=%h tk=%b mp=%b rd=%h, want pc=%h tk=%b mp=%b rd=%h",
                 i, f_pred_pc_o, f_pred_taken_o, m_mispred_o, m_redirect_pc_o,
                 e.pred_pc, e.taken, e.mispred, e.redirect);
      end
      @(posedge clk_i);
      model_update();
    end
`ifdef BPRED_STATS_EN
    #1;
    n_compared++;
    if (stat_branches_o !== stat_b || stat_mispred_o !== stat_m) begin
      n_mismatched++;
      $display("[TB] FAIL test_no_update_stats: got br=%0d mp=%0d, want br=%0d mp=%0d",
               stat_branches_o, stat_mispred_o, stat_b, stat_m);
    end
`endif
  endtask

  // Back-to-back random traffic on a few aliased indices against the model.
  task automatic test_back_to_back();
    exp_t       e;
    logic [3:0] ic;
    logic [3:0] fn;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_i);
      ic = IJXX;
      fn = 4'($urandom_range(1, 6));
      case ($urandom_range(0, 3))
        0: fn = 4'h0;
        3: do ic = 4'($urandom_range(0, 11)); while (ic == IJXX);
        default: ;
      endcase
      set_fetch({32'($urandom), 28'($urandom), 2'b00, 2'($urandom_range(0, 3))}, ic, fn,
                {32'($urandom), 32'($urandom)}, {32'($urandom), 32'($urandom)});
      ic = IJXX;
      fn = 4'($urandom_range(1, 6));
      case ($urandom_range(0, 4))
        0: fn = 4'h0;
        1: do ic = 4'($urandom_range(0, 11)); while (ic == IJXX);
        default: ;
      endcase
      set_mem(1'($urandom_range(0, 7) != 0), {60'($urandom), 2'b00, 2'($urandom_range(0, 3))},
              ic, fn, 1'($urandom), 1'($urandom),
              {32'($urandom), 32'($urandom)}, {32'($urandom), 32'($urandom)});
      sb.push_back(model_expect());
      #2;
      e = sb.pop_front();
      n_compared++;
      if (f_pred_pc_o !== e.pred_pc || f_pred_taken_o !== e.taken ||
          m_mispred_o !== e.mispred || m_redirect_pc_o !== e.redirect) begin
        n_mismatched++;
        $display("[TB] FAIL test_back_to_back[%0d]: got pc=%h tk=%b mp=%b rd=%h, want pc=%h tk=%b mp=%b rd=%h",
                 i, f_pred_pc_o, f_pred_taken_o, m_mispred_o, m_redirect_pc_o,
                 e.pred_pc, e.taken, e.mispred, e.redirect);
      end
      @(posedge clk_i);
      model_update();
    end
  endtask

  // Saturate an entry at 11, then reset between edges with an update pending.
  task automatic test_async_reset();
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      set_fetch(64'h5, IJXX, 4'h4, 64'hA00, 64'h0E);
      set_mem(1'b0, 64'h0, 4'h0, 4'h0, 1'b0, 1'b0, 64'h0, 64'h0);
      if (i < 2) set_mem(1'b1, 64'h15, IJXX, 4'h4, 1'b1, 1'b1, 64'hA00, 64'h1E);
      if (i == 3 || i == 4) set_mem(1'b1, 64'h25, IJXX, 4'h4, 1'b0, 1'b1, 64'hA00, 64'h2E);
      if (i == 3) begin
        #2;
        rst_n_i = 1'b0;
        #1;
        model_reset();
`ifdef BPRED_STATS_EN
        n_compared++;
        if (stat_branches_o !== stat_b || stat_mispred_o !== stat_m) begin
          n_mismatched++;
          $display("[TB] FAIL test_async_reset_stats: got br=%0d mp=%0d, want br=%0d mp=%0d",
                   stat_branches_o, stat_mispred_o, stat_b, stat_m);
        end
`endif
      end
      if (i == 4) rst_n_i = 1'b1;
      sb.push_back(model_expect());
      #1;
      e = sb.pop_front();
      n_compared++;
      if (f_pred_pc_o !== e.pred_pc || f_pred_taken_o !== e.taken ||
          m_mispred_o !== e.mispred || m_redirect_pc_o !== e.redirect) begin
        n_mismatched++;
        $display("[TB] FAIL test_async_reset[%0d]: got pc=%h tk=%b mp=%b rd=%h, want pc=%h tk=%b mp=%b rd=%h",
                 i, f_pred_pc_o, f_pred_taken_o, m_mispred_o, m_redirect_pc_o,
                 e.pred_pc, e.taken, e.mispred, e.redirect);
      end
      @(posedge clk_i);
      model_update();
    end
  endtask

`ifdef BPRED_STATS_EN
  // Preload the mispredict counter close to the top and confirm it sticks at all ones.
  task automatic test_stats_saturation();
    @(negedge clk_i);
    dut.stat_mispred_q = 32'hFFFF_FFFD;
    stat_m = 32'hFFFF_FFFD;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      set_mem(1'b1, 64'h7, IJXX, 4'h3, 1'b1, 1'b0, 64'hB00, 64'h10);
      @(posedge clk_i);
      model_update();
    end
    #1;
    n_compared++;
    if (stat_mispred_o !== 32'hFFFF_FFFF || stat_mispred_o !== stat_m || stat_branches_o !== stat_b) begin
      n_mismatched++;
      $display("[TB] FAIL test_stats_saturation: got br=%0d mp=%h, want br=%0d mp=%h",
               stat_branches_o, stat_mispred_o, stat_b, stat_m);
    end
  endtask
`endif

  // Run every scenario in order and report.
  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    rst_n_i      = 1'b0;
    set_fetch(64'h0, 4'h0, 4'h0, 64'h0, 64'h0);
    set_mem(1'b0, 64'h0, 4'h0, 4'h0, 1'b0, 1'b0, 64'h0, 64'h0);
    model_reset();
    test_reset();
    test_not_taken_train();
    test_same_cycle();
    test_no_update();
    test_back_to_back();
    test_async_reset();
`ifdef BPRED_STATS_EN
    test_stats_saturation();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
